// File: rtl/apb_requester_if.sv
// Command, response and APB signals of apb_requester, bundled in one interface.
// master: the requester's view; slave: the environment driving commands and completing APB.
interface apb_requester_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_slverr;
   logic                  pselx;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, pselx, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, pselx, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_requester.sv
// APB requester: one valid/ready command becomes one SETUP->ACCESS transfer, one outstanding.
// Define APB_TIMEOUT_EN to abort ACCESS with slverr after TIMEOUT_CYCLES cycles without pready.
module apb_requester #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic            pclk,
   input logic            presetn,
   apb_requester_if.master bus
);
   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_slverr_q, rsp_slverr_d;
   logic                  pselx_q, pselx_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   // Without the timeout build the limit has no effect.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_slverr_d = rsp_slverr_q;
      pselx_d      = pselx_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
`ifdef APB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               pwrite_d    = bus.cmd_write;
               paddr_d     = bus.cmd_addr;
               pwdata_d    = bus.cmd_wdata;
               pselx_d     = 1'b1;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b0;
               state_d     = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         StAccess: begin
            if (bus.pready) begin
               rsp_rdata_d  = pwrite_q ? '0 : bus.prdata;
               rsp_slverr_d = bus.pslverr;
               rsp_valid_d  = 1'b1;
               pselx_d      = 1'b0;
               penable_d    = 1'b0;
               state_d      = StResp;
            end
`ifdef APB_TIMEOUT_EN
            // pready on the final allowed cycle still completes normally (branch above).
            else if (cnt_q == CntLast) begin
               rsp_rdata_d  = '0;
               rsp_slverr_d = 1'b1;
               rsp_valid_d  = 1'b1;
               pselx_d      = 1'b0;
               penable_d    = 1'b0;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q      <= StIdle;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_slverr_q <= 1'b0;
         pselx_q      <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_slverr_q <= rsp_slverr_d;
         pselx_q      <= pselx_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
`ifdef APB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.rsp_slverr = rsp_slverr_q;
   assign bus.pselx      = pselx_q;
   assign bus.penable    = penable_q;
   assign bus.pwrite     = pwrite_q;
   assign bus.paddr      = paddr_q;
   assign bus.pwdata     = pwdata_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: one task per scenario with inline expected values.
// Covers the APB_TIMEOUT_EN build when that macro is defined for the bench as well.
module tb_apb_requester;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic pclk    = 1'b0;
   logic presetn = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc        = 0;
   int   n_accept   = 0;
   int   accept_cyc = 0;

   apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_requester #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus)
   );

   always #5 pclk = ~pclk;

   // Cycle counter and command-handshake log, sampled on the active edge.
   always @(posedge pclk) begin
      cyc <= cyc + 1;
      if (bus.cmd_valid && bus.cmd_ready) begin
         n_accept   <= n_accept + 1;
         accept_cyc <= cyc;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
   endtask

   task automatic test_reset();
      presetn = 1'b1;
      #1 presetn = 1'b0;
      #11;
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable, bus.pwrite}
          !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=100000", {bus.cmd_ready, bus.rsp_valid,
                  bus.rsp_slverr, bus.pselx, bus.penable, bus.pwrite});
      end
      checks++;
      if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp=0", bus.paddr,
                  bus.pwdata, bus.rsp_rdata);
      end
      presetn = 1'b1;
      tick();
      checks++;
      if ({bus.cmd_ready, bus.pselx} !== 2'b10) begin
         failures++;
         $display("FAIL reset_release got=%b exp=10", {bus.cmd_ready, bus.pselx});
      end
   endtask

   task automatic test_write();
      bus.pready = 1'b1;
      bus.prdata = 32'h1111_1111;
      send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.pselx, bus.penable, bus.pwrite, bus.cmd_ready} !== 4'b1010) begin
         failures++;
         $display("FAIL wr_setup got=%b exp=1010",
                  {bus.pselx, bus.penable, bus.pwrite, bus.cmd_ready});
      end
      checks++;
      if ({bus.paddr, bus.pwdata} !== {32'h0000_0010, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL wr_addr_data got=%h/%h exp=00000010/deadbeef", bus.paddr, bus.pwdata);
      end
      tick();
      checks++;
      if ({bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid} !== 4'b1110) begin
         failures++;
         $display("FAIL wr_access got=%b exp=1110",
                  {bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid});
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable} !== 4'b1000) begin
         failures++;
         $display("FAIL wr_rsp got=%b exp=1000",
                  {bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable});
      end
      checks++;
      if ({bus.rsp_rdata, bus.paddr} !== {32'h0, 32'h0000_0010}) begin
         failures++;
         $display("FAIL wr_rdata_zero got rdata=%h paddr=%h exp=0/00000010", bus.rsp_rdata,
                  bus.paddr);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL wr_done got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_read_wait();
      int   pen_cnt   = 0;
      logic stable_ok = 1'b1;
      bus.pready = 1'b0;
      bus.prdata = 32'h1234_5678;
      send_cmd(1'b0, 32'h0000_0010, 32'h0);
      tick();
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.pselx, bus.penable, bus.pwrite} !== 3'b100) begin
         failures++;
         $display("FAIL rd_setup got=%b exp=100", {bus.pselx, bus.penable, bus.pwrite});
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.penable === 1'b1) pen_cnt++;
         if (bus.paddr !== 32'h0000_0010 || bus.pselx !== 1'b1 || bus.rsp_valid !== 1'b0)
            stable_ok = 1'b0;
         if (i == 3) begin
            bus.pready = 1'b1;
            bus.prdata = 32'hDEAD_BEEF;
         end
      end
      tick();
      checks++;
      if (pen_cnt != 4) begin
         failures++;
         $display("FAIL rd_penable_cycles got=%0d exp=4", pen_cnt);
      end
      checks++;
      if (stable_ok !== 1'b1) begin
         failures++;
         $display("FAIL rd_wait_stable got=%b exp=1", stable_ok);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable} !== 4'b1000 ||
          bus.rsp_rdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL rd_rsp got=%b rdata=%h exp=1000 deadbeef",
                  {bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable}, bus.rsp_rdata);
      end
      bus.pready = 1'b0;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL rd_done got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_slverr_hold();
      logic hold_ok = 1'b1;
      int   acc0;
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b1;
      bus.pslverr   = 1'b1;
      bus.prdata    = 32'hCAFE_0001;
      send_cmd(1'b0, 32'h0000_0020, 32'h0);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_slverr} !== 2'b11 || bus.rsp_rdata !== 32'hCAFE_0001) begin
         failures++;
         $display("FAIL err_rsp got=%b rdata=%h exp=11 cafe0001",
                  {bus.rsp_valid, bus.rsp_slverr}, bus.rsp_rdata);
      end
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
      acc0 = n_accept;
      send_cmd(1'b1, 32'h0000_0099, 32'h0000_0077);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.rsp_valid !== 1'b1 || bus.rsp_slverr !== 1'b1 ||
             bus.rsp_rdata !== 32'hCAFE_0001 || bus.cmd_ready !== 1'b0 ||
             bus.pselx !== 1'b0 || bus.paddr !== 32'h0000_0020) hold_ok = 1'b0;
      end
      checks++;
      if (hold_ok !== 1'b1) begin
         failures++;
         $display("FAIL err_hold got=%b exp=1", hold_ok);
      end
      checks++;
      if (n_accept != acc0) begin
         failures++;
         $display("FAIL err_cmd_ignored accepts got=%0d exp=%0d", n_accept, acc0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL err_handshake got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_back_to_back();
      int   acc0;
      int   t0;
      logic saw_low = 1'b0;
      bus.pready    = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.prdata    = 32'h0BAD_F00D;
      acc0 = n_accept;
      send_cmd(1'b1, 32'h0000_0030, 32'h0000_0001);
      for (int i = 0; i < 10 && n_accept == acc0; i++) tick();
      checks++;
      if (n_accept != acc0 + 1) begin
         failures++;
         $display("FAIL b2b_first_accept got=%0d exp=%0d", n_accept, acc0 + 1);
      end
      t0 = accept_cyc;
      send_cmd(1'b0, 32'h0000_0034, 32'h0);
      for (int i = 0; i < 10 && n_accept == acc0 + 1; i++) begin
         tick();
         if (bus.pselx === 1'b0) saw_low = 1'b1;
      end
      bus.cmd_valid = 1'b0;
      checks++;
      if (n_accept != acc0 + 2 || accept_cyc - t0 != 4) begin
         failures++;
         $display("FAIL b2b_spacing got accepts=%0d gap=%0d exp=%0d/4", n_accept,
                  accept_cyc - t0, acc0 + 2);
      end
      checks++;
      if (saw_low !== 1'b1) begin
         failures++;
         $display("FAIL b2b_psel_gap got=%b exp=1", saw_low);
      end
      checks++;
      if ({bus.pselx, bus.pwrite} !== 2'b10 || bus.paddr !== 32'h0000_0034) begin
         failures++;
         $display("FAIL b2b_second_setup got=%b paddr=%h exp=10 00000034",
                  {bus.pselx, bus.pwrite}, bus.paddr);
      end
      tick();
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL b2b_second_rsp got=%b rdata=%h exp=1 0badf00d", bus.rsp_valid,
                  bus.rsp_rdata);
      end
      tick();
   endtask

   task automatic test_timeout();
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.prdata    = 32'hFFFF_FFFF;
      send_cmd(1'b0, 32'h0000_0040, 32'h0);
      tick();
      bus.cmd_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
      begin
         logic acc_ok = 1'b1;
         tick();
         for (int k = 1; k <= 16; k++) begin
            if ({bus.pselx, bus.penable, bus.rsp_valid} !== 3'b110) acc_ok = 1'b0;
            if (k < 16) tick();
         end
         checks++;
         if (acc_ok !== 1'b1) begin
            failures++;
            $display("FAIL to_access_cycles got=%b exp=1", acc_ok);
         end
         tick();
         checks++;
         if ({bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable} !== 4'b1100 ||
             bus.rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL to_abort got=%b rdata=%h exp=1100 0",
                     {bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable}, bus.rsp_rdata);
         end
         tick();
      end
`else
      begin
         int held = 0;
         for (int i = 0; i < 110; i++) begin
            tick();
            if (bus.pselx === 1'b1 && bus.penable === 1'b1 && bus.rsp_valid === 1'b0) held++;
         end
         checks++;
         if (held != 110) begin
            failures++;
            $display("FAIL nto_stuck_cycles got=%0d exp=110", held);
         end
         bus.pready = 1'b1;
         bus.prdata = 32'h0000_0055;
         tick();
         checks++;
         if ({bus.rsp_valid, bus.rsp_slverr} !== 2'b10 || bus.rsp_rdata !== 32'h0000_0055) begin
            failures++;
            $display("FAIL nto_late_rsp got=%b rdata=%h exp=10 00000055",
                     {bus.rsp_valid, bus.rsp_slverr}, bus.rsp_rdata);
         end
         bus.pready = 1'b0;
         tick();
      end
`endif
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         failures++;
         $display("FAIL to_done got=%b exp=01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_reset_mid_access();
      bus.pready = 1'b0;
      send_cmd(1'b1, 32'h0000_0050, 32'h0000_ABCD);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      checks++;
      if ({bus.pselx, bus.penable} !== 2'b11) begin
         failures++;
         $display("FAIL rst_mid_pre got=%b exp=11", {bus.pselx, bus.penable});
      end
      #3 presetn = 1'b0;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable, bus.pwrite}
          !== 6'b100000 || {bus.paddr, bus.pwdata, bus.rsp_rdata} !== 96'h0) begin
         failures++;
         $display("FAIL rst_mid_async got=%b paddr=%h pwdata=%h exp=100000 0 0",
                  {bus.cmd_ready, bus.rsp_valid, bus.rsp_slverr, bus.pselx, bus.penable,
                   bus.pwrite}, bus.paddr, bus.pwdata);
      end
      presetn = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.pselx} !== 3'b100) begin
         failures++;
         $display("FAIL rst_mid_release got=%b exp=100", {bus.cmd_ready, bus.rsp_valid,
                  bus.pselx});
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b1;
      bus.prdata    = '0;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_slverr_hold();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
